// File: rtl/imm_ext_stage.sv
// Immediate extension stage: zero/sign/upper/branch extension, 1-cycle registered valid/ready output.
// Define IMM_EXT_STAGE_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module imm_ext_stage #(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [1:0]        in_mode,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   logic [DATA_W-1:0] w_sext;
   logic [DATA_W-1:0] w_ext;
   logic              w_xfer_in;
   logic              r_out_vld;
   logic [DATA_W-1:0] r_out_dat;

   // Extension is computed from the live inputs and captured at acceptance only.
   always_comb begin
      w_sext = DATA_W'($signed(in_imm));
      case (in_mode)
         2'b00:   w_ext = DATA_W'(in_imm);
         2'b01:   w_ext = w_sext;
         2'b10:   w_ext = DATA_W'(in_imm) << (DATA_W - IMM_W);
         default: w_ext = w_sext << 2;
      endcase
   end

   assign out_valid = r_out_vld;
   assign out_data  = r_out_dat;

`ifdef IMM_EXT_STAGE_SKID_EN
   logic              r_in_rdy;
   logic              r_skid_vld;
   logic [DATA_W-1:0] r_skid_dat;
   logic              w_drain;

   assign in_ready  = r_in_rdy;
   assign w_xfer_in = in_valid & r_in_rdy;
   assign w_drain   = ~r_out_vld | out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_vld  <= 1'b0;
         r_out_dat  <= '0;
         r_skid_vld <= 1'b0;
         r_skid_dat <= '0;
         r_in_rdy   <= 1'b0;
      end else if (flush) begin
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
         r_in_rdy   <= 1'b1;
      end else if (w_drain) begin
         // in_ready is low while the skid is full, so no new beat competes here.
         if (r_skid_vld) begin
            r_out_vld  <= 1'b1;
            r_out_dat  <= r_skid_dat;
            r_skid_vld <= 1'b0;
         end else begin
            r_out_vld <= w_xfer_in;
            if (w_xfer_in) r_out_dat <= w_ext;
         end
         r_in_rdy <= 1'b1;
      end else if (w_xfer_in) begin
         r_skid_vld <= 1'b1;
         r_skid_dat <= w_ext;
         r_in_rdy   <= 1'b0;
      end
   end
`else
   assign in_ready  = ~reset & (~r_out_vld | out_ready);
   assign w_xfer_in = in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_vld <= 1'b0;
         r_out_dat <= '0;
      end else if (flush) begin
         r_out_vld <= 1'b0;
      end else if (w_xfer_in) begin
         r_out_vld <= 1'b1;
         r_out_dat <= w_ext;
      end else if (out_ready) begin
         r_out_vld <= 1'b0;
      end
   end
`endif

endmodule
